bcd_generation_counter: RTL and testbench
=========================================

# bcd_generation_counter

Parametrised multi-digit BCD counter with per-digit seven-segment outputs. It counts Game-of-Life generations on the HEX displays. It replaces the per-digit ones/tens/hundreds FSM chain with one block that has:
- a configurable digit count;
- a built-in tick divider;
- leading-zero blanking;
- selectable wrap or saturate behaviour at full scale.

It sits beside the board controller and is driven by the generation-advance enable.

## Interface
Parameters:
- NUM_DIGITS, 3, number of BCD digits (1..6).
- TICK_DIV, 33000000, clock cycles per count tick (≥1). 660 ms at 50 MHz.
- SATURATE, 0, 0 = wrap to zero after all-nines, 1 = hold at all-nines.
- BLANK_LEADING, 1, 1 = blank leading zero digits, 0 = show all digits.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- count_en  in  1  increment request, sampled only on tick cycles.
- clear  in  1  synchronous clear, not tick-gated.
- tick  out  1  one-cycle divider strobe, registered.
- bcd  out  4*NUM_DIGITS  current value; digit 0 is in bits [3:0].
- seg  out  7*NUM_DIGITS  active-low gfedcba per digit; digit 0 is in bits [6:0].
- active  out  1  high when state ≠ IDLE.
- overflow  out  1  one-cycle pulse on an increment request at all-nines.

## Operation
- Divider: a counter runs 0..TICK_DIV-1 continuously and asserts tick for 1 cycle at TICK_DIV-1, then wraps to 0. With TICK_DIV=1, tick is high every cycle. clear does not affect the divider.
- An increment occurs on a cycle where tick=1 and count_en=1 (inc event).
- States:
  - IDLE: display fully blank, bcd=0.
  - COUNTING.
  - SATURATED: only reachable when SATURATE=1.
- Transitions:
  - IDLE --inc--> COUNTING, value becomes 1. The first generation shows "1", not "0".
  - COUNTING --inc, value < max--> COUNTING, value+1 with BCD ripple carry. A digit at 9 goes to 0 and carries into the next digit.
  - COUNTING --inc, value = all-nines, SATURATE=0--> COUNTING, value 0, overflow=1.
  - COUNTING --inc, value = all-nines, SATURATE=1--> SATURATED, value held, overflow=1.
  - SATURATED --inc--> SATURATED, no change, overflow stays 0.
  - Any state --clear--> IDLE, value 0.
- Priority: reset > clear > inc. clear together with inc yields IDLE, value 0, overflow=0.
- Segment decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking:
  - In IDLE, all digits are blank.
  - Otherwise, with BLANK_LEADING=1, digit i>0 is blank if it and all higher digits are 0. Digit 0 is never blank outside IDLE, so a wrapped value shows "0".
  - With BLANK_LEADING=0, all digits are decoded outside IDLE.
- bcd digits never hold values 10..15.

## Timing
- Reset values: state IDLE, bcd=0, seg all 1s, tick=0, overflow=0, active=0, divider=0.
- bcd, state, overflow and tick are registered. seg and active are combinational from registered bcd/state.
- An inc event on cycle N updates bcd and seg, and pulses overflow, at the clock edge ending cycle N. They are visible in cycle N+1, so latency is 1 cycle.
- The tick output is high in the same cycle in which count_en is sampled.
- clear asserted in cycle N gives IDLE/blank in cycle N+1 regardless of tick.
- reset asserted mid-count: all outputs return to reset values in the next cycle. The divider restarts, so the first tick occurs TICK_DIV cycles after reset deasserts.
- count_en changes between ticks have no effect.

## Test plan
- Reset, then count_en=1 with NUM_DIGITS=2, TICK_DIV=4:
  - tick pulses every 4 cycles;
  - after tick 1, bcd=0x01 and seg=1111111_1111001;
  - after tick 10, bcd=0x10 and seg=1111001_1000000.
- Wrap with NUM_DIGITS=2, SATURATE=0, counting to 99 then one more tick:
  - bcd=0x00, overflow high for exactly 1 cycle;
  - seg=1111111_1000000, active=1.
- Saturate with SATURATE=1, at 99, three further ticks:
  - bcd stays 0x99;
  - overflow pulses once only, on the first of these ticks.
- count_en toggled low for 2 of 5 ticks, starting from value 7: final bcd=0x10. Pulses of count_en between ticks cause no change.
- clear:
  - clear in a non-tick cycle at value 42 gives IDLE, seg all 1s, active=0;
  - clear coincident with an inc tick gives IDLE, overflow=0.
- BLANK_LEADING=0, NUM_DIGITS=3: value 5 gives seg=1000000_1000000_0010010. Reset at value 5 gives all outputs at reset values in the next cycle.

Source files
------------

// File: rtl/bcd_generation_counter.sv
// Multi-digit BCD generation counter with seven-segment outputs.
// A free-running divider produces a one-cycle tick; an increment happens
// only when tick and count_en are both high. The value starts at 1 on the
// first increment, ripples in BCD, and either wraps or saturates at
// all-nines. Leading zero digits can be blanked on the display.
//
// Request semantics: count_en is a level request with no ready/ack. It is
// sampled only in cycles where tick=1; its value in any other cycle is
// ignored. clear is sampled every cycle and takes priority over count_en.
module bcd_generation_counter #(
    parameter int NUM_DIGITS    = 3,
    parameter int TICK_DIV      = 33000000,
    parameter int SATURATE      = 0,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    count_en,
    input  logic                    clear,
    output logic                    tick,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    active,
    output logic                    overflow
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [4*NUM_DIGITS-1:0] BCD_ONE = (4*NUM_DIGITS)'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTING  = 2'd1,
        SATURATED = 2'd2
    } state_t;

    state_t                  state;
    logic [DIV_W-1:0]        divCount;
    logic [DIV_W-1:0]        divNext;
    logic                    incEvent;
    logic                    atMax;
    logic [4*NUM_DIGITS-1:0] bcdPlusOne;
    logic [NUM_DIGITS:0]     carryChain;
    logic [NUM_DIGITS:0]     zeroAbove;

    // Seven-segment decode, active-low gfedcba; anything outside 0..9 blanks.
    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        case (digit)
            4'd0:    segDecode = 7'b1000000;
            4'd1:    segDecode = 7'b1111001;
            4'd2:    segDecode = 7'b0100100;
            4'd3:    segDecode = 7'b0110000;
            4'd4:    segDecode = 7'b0011001;
            4'd5:    segDecode = 7'b0010010;
            4'd6:    segDecode = 7'b0000010;
            4'd7:    segDecode = 7'b1111000;
            4'd8:    segDecode = 7'b0000000;
            4'd9:    segDecode = 7'b0010000;
            default: segDecode = 7'b1111111;
        endcase
    endfunction

    // Next divider position: counts 0..TICK_DIV-1 and wraps.
    always_comb begin
        divNext = (divCount == DIV_LAST) ? '0 : divCount + DIV_W'(1);
    end

    // Divider and registered tick; tick is high while the divider sits at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            divCount <= '0;
            tick     <= 1'b0;
        end else begin
            divCount <= divNext;
            tick     <= (divNext == DIV_LAST);
        end
    end

    assign incEvent = tick & count_en;

    // BCD +1 with ripple carry; a carry out of the top digit means all-nines.
    always_comb begin
        carryChain    = '0;
        bcdPlusOne    = '0;
        carryChain[0] = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carryChain[i]) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcdPlusOne[4*i +: 4] = 4'd0;
                    carryChain[i+1]      = 1'b1;
                end else begin
                    bcdPlusOne[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                end
            end else begin
                bcdPlusOne[4*i +: 4] = bcd[4*i +: 4];
            end
        end
    end

    assign atMax = carryChain[NUM_DIGITS];

    // Counter FSM: clear beats increment; overflow is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (clear) begin
                state <= IDLE;
                bcd   <= '0;
            end else if (incEvent) begin
                case (state)
                    IDLE: begin
                        state <= COUNTING;
                        bcd   <= BCD_ONE;
                    end
                    COUNTING: begin
                        if (atMax) begin
                            overflow <= 1'b1;
                            if (SATURATE != 0) begin
                                state <= SATURATED;
                            end else begin
                                bcd <= '0;
                            end
                        end else begin
                            bcd <= bcdPlusOne;
                        end
                    end
                    default: begin
                        // SATURATED holds value and stays put.
                    end
                endcase
            end
        end
    end

    // Display: all blank in IDLE; optionally blank zero digits above the highest nonzero one.
    always_comb begin
        zeroAbove             = '0;
        seg                   = '1;
        zeroAbove[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroAbove[i] = zeroAbove[i+1] & (bcd[4*i +: 4] == 4'd0);
            if ((state == IDLE) || ((BLANK_LEADING != 0) && (i > 0) && zeroAbove[i])) begin
                seg[7*i +: 7] = 7'b1111111;
            end else begin
                seg[7*i +: 7] = segDecode(bcd[4*i +: 4]);
            end
        end
    end

    assign active = (state != IDLE);

endmodule

// File: tb/tb_bcd_generation_counter.sv
// Bench for bcd_generation_counter: three instances with different parameter
// sets share one stimulus stream; an integer-valued reference model checks
// every output of every instance on every cycle, while a vector table and
// short directed sequences pin down the documented corner cases.
module tb_bcd_generation_counter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset    = 1'b1;
    logic count_en = 1'b0;
    logic clear    = 1'b0;

    // u0: 2 digits, div 4, wrap, blanking
    logic        tick0, active0, ovf0;
    logic [7:0]  bcd0;
    logic [13:0] seg0;
    // u1: 2 digits, div 4, saturate, blanking
    logic        tick1, active1, ovf1;
    logic [7:0]  bcd1;
    logic [13:0] seg1;
    // u2: 3 digits, div 1, wrap, no blanking
    logic        tick2, active2, ovf2;
    logic [11:0] bcd2;
    logic [20:0] seg2;

    bcd_generation_counter #(.NUM_DIGITS(2), .TICK_DIV(4), .SATURATE(0), .BLANK_LEADING(1)) u0 (
        .clk(clk), .reset(reset), .count_en(count_en), .clear(clear),
        .tick(tick0), .bcd(bcd0), .seg(seg0), .active(active0), .overflow(ovf0));
    bcd_generation_counter #(.NUM_DIGITS(2), .TICK_DIV(4), .SATURATE(1), .BLANK_LEADING(1)) u1 (
        .clk(clk), .reset(reset), .count_en(count_en), .clear(clear),
        .tick(tick1), .bcd(bcd1), .seg(seg1), .active(active1), .overflow(ovf1));
    bcd_generation_counter #(.NUM_DIGITS(3), .TICK_DIV(1), .SATURATE(0), .BLANK_LEADING(0)) u2 (
        .clk(clk), .reset(reset), .count_en(count_en), .clear(clear),
        .tick(tick2), .bcd(bcd2), .seg(seg2), .active(active2), .overflow(ovf2));

    logic [23:0] d_bcd  [3];
    logic [41:0] d_seg  [3];
    logic        d_tick [3];
    logic        d_act  [3];
    logic        d_ovf  [3];

    assign d_bcd[0] = 24'(bcd0);  assign d_seg[0] = 42'(seg0);
    assign d_bcd[1] = 24'(bcd1);  assign d_seg[1] = 42'(seg1);
    assign d_bcd[2] = 24'(bcd2);  assign d_seg[2] = 42'(seg2);
    assign d_tick[0] = tick0;  assign d_act[0] = active0;  assign d_ovf[0] = ovf0;
    assign d_tick[1] = tick1;  assign d_act[1] = active1;  assign d_ovf[1] = ovf1;
    assign d_tick[2] = tick2;  assign d_act[2] = active2;  assign d_ovf[2] = ovf2;

    // ---------------- reference model ----------------
    int nd  [3] = '{2, 2, 3};
    int td  [3] = '{4, 4, 1};
    int sat [3] = '{0, 1, 0};
    int bl  [3] = '{1, 1, 0};

    int m_val [3];   // displayed value as a plain integer
    int m_st  [3];   // 0 idle, 1 counting, 2 saturated
    int m_k   [3];   // cycles since the reset cycle
    bit m_ovf [3];

    logic [6:0] seg_tab [10];

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit m_tick(input int u);
        return (m_k[u] != 0) && ((m_k[u] % td[u]) == td[u] - 1);
    endfunction

    function automatic logic [23:0] m_bcd(input int u);
        logic [23:0] r = '0;
        for (int i = 0; i < nd[u]; i++) r[4*i +: 4] = 4'((m_val[u] / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [41:0] m_seg(input int u);
        logic [41:0] r = '0;
        for (int i = 0; i < nd[u]; i++) begin
            if (m_st[u] == 0 || (bl[u] != 0 && i > 0 && m_val[u] < pow10(i)))
                r[7*i +: 7] = 7'b1111111;
            else
                r[7*i +: 7] = seg_tab[(m_val[u] / pow10(i)) % 10];
        end
        return r;
    endfunction

    task automatic model_edge(input bit rst, input bit ce, input bit clr);
        for (int u = 0; u < 3; u++) begin
            bit inc;
            inc = m_tick(u) && ce;
            if (rst) begin
                m_val[u] = 0; m_st[u] = 0; m_ovf[u] = 1'b0; m_k[u] = 0;
            end else begin
                m_k[u]   = m_k[u] + 1;
                m_ovf[u] = 1'b0;
                if (clr) begin
                    m_st[u] = 0; m_val[u] = 0;
                end else if (inc) begin
                    if (m_st[u] == 0) begin
                        m_st[u] = 1; m_val[u] = 1;
                    end else if (m_st[u] == 1) begin
                        if (m_val[u] == pow10(nd[u]) - 1) begin
                            m_ovf[u] = 1'b1;
                            if (sat[u] != 0) m_st[u] = 2;
                            else m_val[u] = 0;
                        end else begin
                            m_val[u] = m_val[u] + 1;
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int u, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s u%0d @%0t: got %0h, expected %0h", name, u, $time, act, exp);
    endtask

    task automatic check_all();
        for (int u = 0; u < 3; u++) begin
            chk("tick",     u, 64'(d_tick[u]), 64'(m_tick(u)));
            chk("bcd",      u, 64'(d_bcd[u]),  64'(m_bcd(u)));
            chk("seg",      u, 64'(d_seg[u]),  64'(m_seg(u)));
            chk("active",   u, 64'(d_act[u]),  64'(m_st[u] != 0));
            chk("overflow", u, 64'(d_ovf[u]),  64'(m_ovf[u]));
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic step(input bit rst, input bit ce, input bit clr);
        reset = rst; count_en = ce; clear = clr;
        @(posedge clk);
        model_edge(rst, ce, clr);
        @(negedge clk);
        check_all();
    endtask

    // Run whole divide-by-4 periods with count_en held; stays tick-aligned for u0/u1.
    task automatic run_ticks(input int n, input bit ce);
        repeat (n * 4) step(1'b0, ce, 1'b0);
    endtask

    // Clear in the first (non-tick) cycle of a period, then finish the period.
    task automatic clear_period();
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit          ce;
        int          ticks;
        logic [7:0]  bcd0;
        logic [13:0] seg0;
        bit          ovf0;
        logic [7:0]  bcd1;
        bit          ovf1;
    } vec_t;

    vec_t tbl [7];
    bit   pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        tbl[0] = '{1'b1, 1,  8'h01, 14'b1111111_1111001, 1'b0, 8'h01, 1'b0};
        tbl[1] = '{1'b1, 9,  8'h10, 14'b1111001_1000000, 1'b0, 8'h10, 1'b0};
        tbl[2] = '{1'b1, 89, 8'h99, 14'b0010000_0010000, 1'b0, 8'h99, 1'b0};
        tbl[3] = '{1'b1, 1,  8'h00, 14'b1111111_1000000, 1'b1, 8'h99, 1'b1};
        tbl[4] = '{1'b1, 1,  8'h01, 14'b1111111_1111001, 1'b0, 8'h99, 1'b0};
        tbl[5] = '{1'b1, 1,  8'h02, 14'b1111111_0100100, 1'b0, 8'h99, 1'b0};
        tbl[6] = '{1'b0, 2,  8'h02, 14'b1111111_0100100, 1'b0, 8'h99, 1'b0};
        foreach (tbl[i]) exp_q.push_back(tbl[i].bcd0);

        // Reset state
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_seg", 0, 64'(seg0), 64'(14'h3FFF));
        chk("rst_bcd", 2, 64'(bcd2), 64'(12'h000));
        chk("rst_tick", 0, 64'(tick0), 64'(1'b0));

        // Vector table: count up, wrap/saturate, then hold with count_en low
        foreach (tbl[i]) begin
            logic [7:0] e;
            run_ticks(tbl[i].ticks, tbl[i].ce);
            e = exp_q.pop_front();
            chk("tbl_bcd0", 0, 64'(bcd0), 64'(e));
            chk("tbl_seg0", 0, 64'(seg0), 64'(tbl[i].seg0));
            chk("tbl_ovf0", 0, 64'(ovf0), 64'(tbl[i].ovf0));
            chk("tbl_act0", 0, 64'(active0), 64'(1'b1));
            chk("tbl_bcd1", 1, 64'(bcd1), 64'(tbl[i].bcd1));
            chk("tbl_ovf1", 1, 64'(ovf1), 64'(tbl[i].ovf1));
        end

        // count_en low for 2 of 5 ticks from 7, with pulses between ticks
        clear_period();
        run_ticks(7, 1'b1);
        chk("seq7_bcd", 0, 64'(bcd0), 64'(8'h07));
        for (int p = 0; p < 5; p++) begin
            repeat (3) step(1'b0, !pat[p], 1'b0);
            step(1'b0, pat[p], 1'b0);
        end
        chk("toggle_bcd", 0, 64'(bcd0), 64'(8'h10));

        // clear in a non-tick cycle at 42
        clear_period();
        run_ticks(42, 1'b1);
        chk("at42_bcd", 0, 64'(bcd0), 64'(8'h42));
        step(1'b0, 1'b0, 1'b1);
        chk("clr_seg", 0, 64'(seg0), 64'(14'h3FFF));
        chk("clr_act", 0, 64'(active0), 64'(1'b0));
        chk("clr_bcd", 0, 64'(bcd0), 64'(8'h00));
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // clear coincident with an increment tick at all-nines
        run_ticks(99, 1'b1);
        chk("at99_bcd", 0, 64'(bcd0), 64'(8'h99));
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("clrinc_ovf0", 0, 64'(ovf0), 64'(1'b0));
        chk("clrinc_act0", 0, 64'(active0), 64'(1'b0));
        chk("clrinc_ovf1", 1, 64'(ovf1), 64'(1'b0));
        chk("clrinc_bcd1", 1, 64'(bcd1), 64'(8'h00));

        // No blanking, 3 digits, value 5; then reset mid-count
        step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        chk("nb_bcd", 2, 64'(bcd2), 64'(12'h005));
        chk("nb_seg", 2, 64'(seg2), 64'(21'b1000000_1000000_0010010));
        step(1'b1, 1'b1, 1'b0);
        chk("mid_rst_bcd2", 2, 64'(bcd2), 64'(12'h000));
        chk("mid_rst_seg2", 2, 64'(seg2), 64'(21'h1FFFFF));
        chk("mid_rst_act2", 2, 64'(active2), 64'(1'b0));
        chk("mid_rst_tick2", 2, 64'(tick2), 64'(1'b0));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("first_tick_early", 0, 64'(tick0), 64'(1'b0));
        step(1'b0, 1'b0, 1'b0);
        chk("first_tick", 0, 64'(tick0), 64'(1'b1));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit r, c, e;
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 9) != 0);
            step(r, e, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
